// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory and datapath signals of the fetch unit
interface instruction_fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Fault;

    modport master (
        output IMemReq, IMemAddr, Instruction, InstrPC, InstrValid, Fault,
        input  IMemAck, IMemData, InstrReady, Redirect, RedirectPC
    );

    modport slave (
        input  IMemReq, IMemAddr, Instruction, InstrPC, InstrValid, Fault,
        output IMemAck, IMemData, InstrReady, Redirect, RedirectPC
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, one-outstanding imem reads, prefetch queue, redirect (IFU_MISALIGN_CHECK_EN)
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input logic                      CLK,
    input logic                      Reset,
    instruction_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2, S_FAULT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2} state_t;
`endif

    state_t r_state;
    state_t w_state_nxt;
    state_t w_redir_dest;
    state_t w_drain_dest;

    logic [31:0]      r_pc;
    logic [31:0]      r_imem_addr;
    logic             r_imem_req;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;
    logic             r_valid;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_pc    [QDEPTH];
    logic [31:0]      r_mem_instr [QDEPTH];

    logic [31:0]      w_rpc;
    logic             w_redir;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_count_pop;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_addr_nxt;
    logic             w_req_nxt;
    logic             w_valid_nxt;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_instr;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_fault;
    logic r_fault_pend;
    logic w_misalign;

    assign w_misalign   = |bus.RedirectPC[1:0];
    assign w_rpc        = bus.RedirectPC;
    // FAULT is terminal until reset, so later redirects are ignored there
    assign w_redir      = bus.Redirect & (r_state != S_FAULT);
    assign w_redir_dest = w_misalign ? S_FAULT : S_FETCH;
    assign w_drain_dest = r_fault_pend ? S_FAULT : S_FETCH;
    assign bus.Fault    = r_fault;

    // remember whether the latest redirect target was misaligned while the old read drains
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_fault_pend <= 1'b0;
        end else if (w_redir) begin
            r_fault_pend <= w_misalign;
        end
    end

    // sticky fault flag, raised on entry to FAULT
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= r_fault | (w_state_nxt == S_FAULT);
        end
    end
`else
    assign w_rpc        = bus.RedirectPC & 32'hFFFF_FFFC;
    assign w_redir      = bus.Redirect;
    assign w_redir_dest = S_FETCH;
    assign w_drain_dest = S_FETCH;
    assign bus.Fault    = 1'b0;
`endif

    // a redirect wins over push and pop in the same cycle
    assign w_pop       = r_valid & bus.InstrReady & ~w_redir;
    assign w_push      = (r_state == S_FETCH) & bus.IMemAck & ~w_redir;
    assign w_count_pop = r_count - CNT_W'(w_pop);
    assign w_count_nxt = w_redir ? '0 : (w_count_pop + CNT_W'(w_push));
    assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);

    // state register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_redir) begin
                    w_state_nxt = w_redir_dest;
                end else if (w_count_pop < DEPTH_C) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_redir) begin
                    w_state_nxt = bus.IMemAck ? w_redir_dest : S_DRAIN;
                end else if (bus.IMemAck) begin
                    w_state_nxt = (w_count_nxt < DEPTH_C) ? S_FETCH : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.IMemAck) begin
                    w_state_nxt = w_redir ? w_redir_dest : w_drain_dest;
                end
            end
`ifdef IFU_MISALIGN_CHECK_EN
            S_FAULT: w_state_nxt = S_FAULT;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // next values of the registered outputs, including the queue head after this cycle's push/pop
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_redir) begin
            w_pc_nxt = w_rpc;
        end else if (w_push) begin
            w_pc_nxt = r_pc + 32'd4;
        end
        // a draining request keeps presenting the address memory is still working on
        w_addr_nxt  = (w_state_nxt == S_DRAIN) ? r_imem_addr : w_pc_nxt;
        w_req_nxt   = (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN);
        w_valid_nxt = (w_count_nxt != '0);
        // the new head is the word being pushed when nothing older remains after the pop
        if (w_push && (w_rd_nxt == r_wr_ptr)) begin
            w_head_pc    = r_pc;
            w_head_instr = bus.IMemData;
        end else begin
            w_head_pc    = r_mem_pc[w_rd_nxt];
            w_head_instr = r_mem_instr[w_rd_nxt];
        end
    end

    // queue pointers and occupancy
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_redir) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
        end
    end

    // queue storage written on every accepted fetch
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= bus.IMemData;
        end
    end

    // fetch PC and registered outputs
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_pc        <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_imem_addr <= w_addr_nxt;
            r_imem_req  <= w_req_nxt;
            r_valid     <= w_valid_nxt;
            if (w_valid_nxt) begin
                r_instr    <= w_head_instr;
                r_instr_pc <= w_head_pc;
            end
        end
    end

    assign bus.IMemReq     = r_imem_req;
    assign bus.IMemAddr    = r_imem_addr;
    assign bus.InstrValid  = r_valid;
    assign bus.Instruction = r_instr;
    assign bus.InstrPC     = r_instr_pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector table plus randomized run against a queue-based model
module tb_instruction_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          QD  = 2;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rdy;
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t vt[19];

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_drain;
    bit          m_pend;
    bit          m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic ack, input logic redir, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic e_fault);
        vec_t v;
        v.rdy = rdy; v.ack = ack; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = RPC;
        m_addr  = RPC;
        m_req   = 0;
        m_drain = 0;
        m_pend  = 0;
        m_fault = 0;
    endtask

    // one clock of the fetch unit described in terms of queue contents and the outstanding read
    task automatic model_step(input bit rdy, input bit ack, input logic [31:0] data,
                              input bit redir, input logic [31:0] rpc);
        bit          pop;
        bit          acked;
        bit          mis;
        logic [31:0] tgt;
        pop   = (mq.size() > 0) && rdy;
        acked = m_req && ack;
`ifdef IFU_MISALIGN_CHECK_EN
        tgt = rpc;
        mis = (rpc % 4) != 0;
`else
        tgt = rpc - (rpc % 4);
        mis = 0;
`endif
        if (m_fault) return;
        if (redir) begin
            mq.delete();
            m_pc = tgt;
            if (m_req && !acked) begin
                m_drain = 1;
                m_pend  = mis;
            end else if (mis) begin
                m_fault = 1;
                m_req   = 0;
                m_drain = 0;
            end else begin
                m_drain = 0;
                m_req   = 1;
                m_addr  = m_pc;
            end
        end else if (m_drain) begin
            if (acked) begin
                m_drain = 0;
                if (m_pend) begin
                    m_fault = 1;
                    m_req   = 0;
                end else begin
                    m_addr = m_pc;
                end
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (acked) begin
                mq.push_back('{pc: m_pc, instr: data});
                m_pc = m_pc + 32'd4;
            end
            m_req  = mq.size() < QD;
            m_addr = m_pc;
        end
    endtask

    task automatic model_compare(input string tag);
        chk({tag, "_req"}, {31'd0, bus.IMemReq}, {31'd0, m_req});
        if (m_req) chk({tag, "_addr"}, bus.IMemAddr, m_addr);
        chk({tag, "_valid"}, {31'd0, bus.InstrValid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk({tag, "_pc"}, bus.InstrPC, mq[0].pc);
            chk({tag, "_instr"}, bus.Instruction, mq[0].instr);
        end
        chk({tag, "_fault"}, {31'd0, bus.Fault}, {31'd0, m_fault});
    endtask

    initial begin
        logic [31:0] cur_addr;
        bus.IMemAck    = 1'b0;
        bus.IMemData   = '0;
        bus.InstrReady = 1'b0;
        bus.Redirect   = 1'b0;
        bus.RedirectPC = '0;

        vt[0]  = mk(1, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         0);
        vt[1]  = mk(1, 1, 0, 32'h0,         1, 32'h104,       1, 32'h100,       0);
        vt[2]  = mk(1, 1, 0, 32'h0,         1, 32'h108,       1, 32'h104,       0);
        vt[3]  = mk(1, 1, 0, 32'h0,         1, 32'h10C,       1, 32'h108,       0);
        vt[4]  = mk(0, 1, 0, 32'h0,         0, 32'h110,       1, 32'h108,       0);
        vt[5]  = mk(0, 0, 0, 32'h0,         0, 32'h110,       1, 32'h108,       0);
        vt[6]  = mk(1, 0, 0, 32'h0,         1, 32'h110,       1, 32'h10C,       0);
        vt[7]  = mk(0, 0, 0, 32'h0,         1, 32'h110,       1, 32'h10C,       0);
        vt[8]  = mk(0, 0, 1, 32'h200,       1, 32'h110,       0, 32'h0,         0);
        vt[9]  = mk(0, 0, 0, 32'h0,         1, 32'h110,       0, 32'h0,         0);
        vt[10] = mk(0, 1, 0, 32'h0,         1, 32'h200,       0, 32'h0,         0);
        vt[11] = mk(1, 1, 0, 32'h0,         1, 32'h204,       1, 32'h200,       0);
        vt[12] = mk(1, 1, 1, 32'h40,        1, 32'h40,        0, 32'h0,         0);
        vt[13] = mk(1, 1, 0, 32'h0,         1, 32'h44,        1, 32'h40,        0);
        vt[14] = mk(1, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        vt[15] = mk(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC, 0);
        vt[16] = mk(1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0,         0);
`ifdef IFU_MISALIGN_CHECK_EN
        vt[17] = mk(1, 1, 1, 32'h202,       0, 32'h0,         0, 32'h0,         1);
        vt[18] = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1);
`else
        vt[17] = mk(1, 1, 1, 32'h202,       1, 32'h200,       0, 32'h0,         0);
        vt[18] = mk(1, 1, 0, 32'h0,         1, 32'h204,       1, 32'h200,       0);
`endif

        repeat (2) @(negedge CLK);
        chk("rst_req",   {31'd0, bus.IMemReq},    32'd0);
        chk("rst_addr",  bus.IMemAddr,            RPC);
        chk("rst_valid", {31'd0, bus.InstrValid}, 32'd0);
        chk("rst_instr", bus.Instruction,         32'd0);
        chk("rst_pc",    bus.InstrPC,             32'd0);
        chk("rst_fault", {31'd0, bus.Fault},      32'd0);

        Reset    = 1'b0;
        cur_addr = RPC;
        for (int i = 0; i < 19; i++) begin
            bus.InstrReady = vt[i].rdy;
            bus.IMemAck    = vt[i].ack;
            bus.IMemData   = mdata(cur_addr);
            bus.Redirect   = vt[i].redir;
            bus.RedirectPC = vt[i].rpc;
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("vec%0d_req", i), {31'd0, bus.IMemReq}, {31'd0, vt[i].e_req});
            if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), bus.IMemAddr, vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.InstrValid}, {31'd0, vt[i].e_valid});
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), bus.InstrPC, vt[i].e_pc);
                chk($sformatf("vec%0d_instr", i), bus.Instruction, mdata(vt[i].e_pc));
            end
            chk($sformatf("vec%0d_fault", i), {31'd0, bus.Fault}, {31'd0, vt[i].e_fault});
            cur_addr = vt[i].e_addr;
        end

        for (int b = 0; b < 6; b++) begin
            int ack_odds;
            ack_odds = 1 + (b % 3);
            Reset = 1'b1;
            model_reset();
            @(posedge CLK);
            @(negedge CLK);
            model_compare($sformatf("rnd%0d_rst", b));
            Reset = 1'b0;
            for (int c = 0; c < 400; c++) begin
                bit          rdy;
                bit          ack;
                bit          redir;
                logic [31:0] rpc;
                logic [31:0] data;
                rdy   = $urandom_range(0, 3) != 0;
                ack   = $urandom_range(0, ack_odds) == 0;
                redir = $urandom_range(0, 15) == 0;
                data  = $urandom;
                rpc   = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
                if ($urandom_range(0, 31) == 0) rpc = rpc | 32'h2;
                bus.InstrReady = rdy;
                bus.IMemAck    = ack;
                bus.IMemData   = data;
                bus.Redirect   = redir;
                bus.RedirectPC = rpc;
                model_step(rdy, ack, data, redir, rpc);
                @(posedge CLK);
                @(negedge CLK);
                model_compare($sformatf("rnd%0d_c%0d", b, c));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch unit that drives the `Instruction` input of the full datapath. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake with one outstanding request. Returned words go into a small prefetch queue, which presents them to the datapath with a valid/ready handshake. A branch redirect from the branch-compare stage flushes the queue and restarts fetch at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `QDEPTH`, default 2: prefetch queue entries; power of two, 2..8.

Ports:
- `CLK` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `IMemReq` output 1: read request to instruction memory.
- `IMemAddr` output 32: word-aligned read address.
- `IMemAck` input 1: memory accepts the request; `IMemData` is valid in the same cycle.
- `IMemData` input 32: read data.
- `Instruction` output 32: queue head instruction.
- `InstrPC` output 32: PC of the queue head.
- `InstrValid` output 1: queue not empty.
- `InstrReady` input 1: datapath consumes the head this cycle.
- `Redirect` input 1: taken branch.
- `RedirectPC` input 32: branch target.
- `Fault` output 1: misaligned redirect seen; only meaningful with the configuration macro.

## Operation
FSM states are IDLE, FETCH, DRAIN and FAULT. `IMemReq` is 1 only in FETCH and DRAIN.

Queue:
- Holds `QDEPTH` entries of {pc, instr}, ordered by circular read/write pointers plus a count.
- A push happens on a FETCH ack.
- A pop happens when `InstrValid & InstrReady`.
- Push and pop in the same cycle are allowed, including when the queue is full, and leave the count unchanged.

FSM transitions:
- **IDLE:** go to FETCH when the post-pop count of this cycle is less than `QDEPTH`.
- **FETCH:**
  - `IMemAddr` = fetch PC, held stable until ack.
  - On ack: push {fetch PC, `IMemData`} and set fetch PC += 4.
  - After the ack, stay in FETCH if the post-push/pop count is less than `QDEPTH`; otherwise go to IDLE.
  - A request is only issued when a slot is free, so an ack never overflows the queue.
- **DRAIN:** the request is still outstanding after a redirect.
  - Hold the old address until ack, then discard the data.
  - Then go to FETCH at the stored target, or to FAULT if the fault is pending.

Redirect rules:
- A redirect has priority over push and pop that cycle.
- Effects: queue flushed (count=0), fetch PC ← `RedirectPC`.
- Next state depends on where the FSM is:
  - IDLE, or FETCH with ack in the same cycle: go to FETCH. Any same-cycle data is discarded.
  - FETCH without ack: go to DRAIN.
  - DRAIN: stay in DRAIN with the target replaced.

Arithmetic:
- Fetch PC increments by 4, modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000, with no flag.

Reset:
- Outputs: `IMemReq`=0, `IMemAddr`=`RESET_PC`, `InstrValid`=0, `Instruction`=0, `InstrPC`=0, `Fault`=0.
- State: IDLE with an empty queue.
- Asserting `Reset` mid-request drops the request immediately. Memory must tolerate `IMemReq` falling before ack.

## Timing
- First request: `IMemReq`=1 with `IMemAddr`=`RESET_PC` in the first cycle after the first rising edge following `Reset` deassertion.
- Ack to head: the word is visible on `Instruction`/`InstrValid` the cycle after the ack edge. There is no same-cycle bypass.
- Back-to-back: with single-cycle ack and a continuously ready consumer, sustained throughput is 1 instruction per cycle after the initial 2-cycle fill.
- Redirect with no request outstanding: `IMemReq` with `RedirectPC` in the next cycle, and `InstrValid`=0 in the next cycle.
- Redirect with a request outstanding: the new request appears the cycle after the drained ack.
- All outputs are registered.

## Configuration
`IFU_MISALIGN_CHECK_EN`:
- **Defined:**
  - A redirect with `RedirectPC[1:0]` ≠ 0 flushes the queue and enters FAULT, via DRAIN if a request is outstanding.
  - `Fault` rises on entry to FAULT and stays sticky until `Reset`.
  - No further requests are issued and `InstrValid` stays 0.
- **Undefined:** `RedirectPC[1:0]` is forced to 00, `Fault` is tied 0, and the FAULT state is removed.

## Test plan
- Reset with `RESET_PC`=32'h100, memory acks each request on its first cycle, `InstrReady`=1 → `InstrPC` sequence 0x100, 0x104, 0x108 on consecutive cycles starting 2 cycles after reset release; `IMemReq` is never low after the first request.
- `InstrReady`=0, `QDEPTH`=2 → exactly 2 acks, then `IMemReq`=0. Raising `InstrReady` for one cycle → one pop and one new request the next cycle.
- Memory with 3-cycle ack latency; redirect to 0x200 during wait cycle 1 → old address held until ack, that data discarded, next request at 0x200, no stale `InstrValid`.
- Redirect to 0x40 in the same cycle as an ack and a pop → queue empty next cycle, next `IMemAddr`=0x40.
- Fetch PC at 32'hFFFF_FFFC → next `IMemAddr`=0.
- With `IFU_MISALIGN_CHECK_EN`, redirect to 0x202 → `Fault`=1 next cycle, `IMemReq` stays 0 and `InstrValid` stays 0 until `Reset`. Without the macro, fetch proceeds at 0x200.
